// File: rtl/swap_reg_ctrl.sv
// Round-robin controller that grants one of NREQ requesters access to a
// swap register file and sequences either a single WRITE or a burst of
// address-pair SWAP strobes. All outputs come straight from flops.
module swap_reg_ctrl #(
  parameter int NREQ       = 2,
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            op,
  input  logic [NREQ*ADDR_WIDTH-1:0] addr_a,
  input  logic [NREQ*ADDR_WIDTH-1:0] addr_b,
  input  logic [NREQ*DATA_WIDTH-1:0] wdata,
  input  logic [NREQ*CNT_WIDTH-1:0]  cnt,
  output logic [NREQ-1:0]            ack,
  output logic [NREQ-1:0]            err,
  output logic                       busy,
  output logic [$clog2(NREQ)-1:0]    grant_id,
  output logic                       rf_we,
  output logic [ADDR_WIDTH-1:0]      rf_address_w,
  output logic [DATA_WIDTH-1:0]      rf_data_w,
  output logic [ADDR_WIDTH-1:0]      rf_address_A,
  output logic [ADDR_WIDTH-1:0]      rf_address_B,
  output logic                       rf_swap
);

  localparam int GW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_r, state_next_s;
  logic [GW-1:0]         rr_r, rr_next_s;
  logic                  op_r, op_next_s;
  logic [CNT_WIDTH-1:0]  cnt_r, cnt_next_s;
  logic [GW-1:0]         grant_next_s;
  logic [NREQ-1:0]       ack_next_s, err_next_s;
  logic                  busy_next_s, we_next_s, swap_next_s;
  logic [ADDR_WIDTH-1:0] aw_next_s, aa_next_s, ab_next_s;
  logic [DATA_WIDTH-1:0] dw_next_s;

  logic                  sel_found_s;
  logic [GW-1:0]         sel_s, idx_s;
  logic                  sel_op_s;
  logic [ADDR_WIDTH-1:0] sel_a_s, sel_b_s;
  logic [DATA_WIDTH-1:0] sel_d_s;
  logic [CNT_WIDTH-1:0]  sel_cnt_s;
  logic                  sel_reject_s;

  // Pick the first requester at or after the round-robin pointer (wrapping).
  always_comb begin
    sel_found_s = 1'b0;
    sel_s       = '0;
    idx_s       = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx_s = GW'((int'(rr_r) + i) % NREQ);
      if (req[idx_s]) begin
        sel_found_s = 1'b1;
        sel_s       = idx_s;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Extract the winner's fields and decide whether its op must be rejected.
  always_comb begin
    sel_op_s     = op[sel_s];
    sel_a_s      = addr_a[sel_s*ADDR_WIDTH +: ADDR_WIDTH];
    sel_b_s      = addr_b[sel_s*ADDR_WIDTH +: ADDR_WIDTH];
    sel_d_s      = wdata[sel_s*DATA_WIDTH +: DATA_WIDTH];
    sel_cnt_s    = cnt[sel_s*CNT_WIDTH +: CNT_WIDTH];
    sel_reject_s = sel_op_s && ((sel_cnt_s == CNT_WIDTH'(0)) || (sel_a_s == sel_b_s));
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead.
  always_comb begin
    state_next_s = state_r;
    rr_next_s    = rr_r;
    op_next_s    = op_r;
    cnt_next_s   = cnt_r;
    grant_next_s = grant_id;
    ack_next_s   = '0;
    err_next_s   = '0;
    we_next_s    = 1'b0;
    swap_next_s  = 1'b0;
    aw_next_s    = rf_address_w;
    dw_next_s    = rf_data_w;
    aa_next_s    = rf_address_A;
    ab_next_s    = rf_address_B;
    case (state_r)
      IDLE: begin
        if (sel_found_s) begin
          grant_next_s = sel_s;
          op_next_s    = sel_op_s;
          if (sel_reject_s) begin
            state_next_s       = DONE;
            ack_next_s[sel_s]  = 1'b1;
            err_next_s[sel_s]  = 1'b1;
          end else if (sel_op_s) begin
            state_next_s = EXEC;
            swap_next_s  = 1'b1;
            aa_next_s    = sel_a_s;
            ab_next_s    = sel_b_s;
            cnt_next_s   = sel_cnt_s - CNT_WIDTH'(1);
          end else begin
            state_next_s = EXEC;
            we_next_s    = 1'b1;
            aw_next_s    = sel_a_s;
            dw_next_s    = sel_d_s;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      EXEC: begin
        if (op_r && (cnt_r != CNT_WIDTH'(0))) begin
          swap_next_s = 1'b1;
          cnt_next_s  = cnt_r - CNT_WIDTH'(1);
        end else begin
          state_next_s         = DONE;
          ack_next_s[grant_id] = 1'b1;
        end
      end
      DONE: begin
        state_next_s = IDLE;
        if (grant_id == GW'(NREQ - 1)) begin
          rr_next_s = '0;
        end else begin
          rr_next_s = grant_id + GW'(1);
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
    busy_next_s = (state_next_s != IDLE);
  end

  // State, pointer and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      rr_r         <= '0;
      op_r         <= 1'b0;
      cnt_r        <= '0;
      grant_id     <= '0;
      ack          <= '0;
      err          <= '0;
      busy         <= 1'b0;
      rf_we        <= 1'b0;
      rf_swap      <= 1'b0;
      rf_address_w <= '0;
      rf_data_w    <= '0;
      rf_address_A <= '0;
      rf_address_B <= '0;
    end else begin
      state_r      <= state_next_s;
      rr_r         <= rr_next_s;
      op_r         <= op_next_s;
      cnt_r        <= cnt_next_s;
      grant_id     <= grant_next_s;
      ack          <= ack_next_s;
      err          <= err_next_s;
      busy         <= busy_next_s;
      rf_we        <= we_next_s;
      rf_swap      <= swap_next_s;
      rf_address_w <= aw_next_s;
      rf_data_w    <= dw_next_s;
      rf_address_A <= aa_next_s;
      rf_address_B <= ab_next_s;
    end
  end

endmodule

// File: tb/tb_swap_reg_ctrl.sv
// Bench for swap_reg_ctrl: vector table of single ops, scoreboard of
// expected completions, plus hand sequences for arbitration and reset abort.
module tb_swap_reg_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, op;
  logic [13:0] addr_a, addr_b;
  logic [15:0] wdata;
  logic [7:0]  cnt;
  logic [1:0]  ack, err;
  logic        busy;
  logic [0:0]  grant_id;
  logic        rf_we, rf_swap;
  logic [6:0]  rf_address_w, rf_address_A, rf_address_B;
  logic [7:0]  rf_data_w;

  swap_reg_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .addr_a(addr_a), .addr_b(addr_b),
    .wdata(wdata), .cnt(cnt), .ack(ack), .err(err), .busy(busy), .grant_id(grant_id),
    .rf_we(rf_we), .rf_address_w(rf_address_w), .rf_data_w(rf_data_w),
    .rf_address_A(rf_address_A), .rf_address_B(rf_address_B), .rf_swap(rf_swap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       id;
    bit       op;
    int       a;
    int       b;
    int       d;
    int       cnt;
    bit       exp_err;
    int       exp_lat;
  } vec_t;

  typedef struct {
    int id;
    bit is_write;
    int aw;
    int dw;
    int a;
    int b;
    int nsw;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // register file model fed by the controller's strobes
  logic [7:0] rf_m [128];

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  // Register file model: apply writes and swaps on the clock edge.
  always @(posedge clk) begin
    if (rf_we) rf_m[rf_address_w] <= rf_data_w;
    if (rf_swap) begin
      rf_m[rf_address_A] <= rf_m[rf_address_B];
      rf_m[rf_address_B] <= rf_m[rf_address_A];
    end
  end

  int   m_nwr = 0, m_nsw = 0, m_aw = 0, m_dw = 0, m_a = 0, m_b = 0;

  // Monitor: accumulate strobes per op and compare against the scoreboard on ack.
  always @(negedge clk) begin
    if (reset) begin
      m_nwr = 0;
      m_nsw = 0;
    end else begin
      if (rf_we) begin
        m_nwr++;
        m_aw = rf_address_w;
        m_dw = rf_data_w;
      end
      if (rf_swap) begin
        if (m_nsw == 0) begin
          m_a = rf_address_A;
          m_b = rf_address_B;
        end else begin
          check("swap_addrA_stable", rf_address_A, m_a);
          check("swap_addrB_stable", rf_address_B, m_b);
        end
        m_nsw++;
      end
      if (ack != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", int'(ack), 0);
        end else begin
          exp_t e;
          logic [1:0] eo;
          e  = exp_q.pop_front();
          eo = 2'b01 << e.id;
          check("ack_onehot", int'(ack), int'(eo));
          check("grant_id", int'(grant_id), e.id);
          check("err", int'(err), e.err ? int'(eo) : 0);
          check("n_writes", m_nwr, e.is_write ? 1 : 0);
          check("n_swaps", m_nsw, e.nsw);
          if (e.is_write) begin
            check("write_addr", m_aw, e.aw);
            check("write_data", m_dw, e.dw);
          end
          if (e.nsw > 0) begin
            check("swap_addrA", m_a, e.a);
            check("swap_addrB", m_b, e.b);
          end
        end
        m_nwr = 0;
        m_nsw = 0;
      end
    end
  end

  task automatic drive_fields(input vec_t v);
    op[v.id]                = v.op;
    addr_a[v.id*7 +: 7]     = 7'(v.a);
    addr_b[v.id*7 +: 7]     = 7'(v.b);
    wdata[v.id*8 +: 8]      = 8'(v.d);
    cnt[v.id*4 +: 4]        = 4'(v.cnt);
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.id       = v.id;
    e.is_write = !v.op && !v.exp_err;
    e.aw       = v.a;
    e.dw       = v.d;
    e.a        = v.a;
    e.b        = v.b;
    e.nsw      = (v.op && !v.exp_err) ? v.cnt : 0;
    e.err      = v.exp_err;
    exp_q.push_back(e);
  endtask

  task automatic run_op(input vec_t v);
    int lat;
    bit got;
    lat = 0;
    got = 1'b0;
    @(negedge clk);
    drive_fields(v);
    push_exp(v);
    req[v.id] = 1'b1;
    for (int c = 0; c < 40 && !got; c++) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (ack[v.id]) got = 1'b1;
    end
    req[v.id] = 1'b0;
    check("ack_seen", int'(got), 1);
    check("latency", lat, v.exp_lat);
    @(posedge clk);
    @(negedge clk);
    check("idle_after_op", int'(busy), 0);
  endtask

  vec_t vecs [8];

  initial begin
    vec_t v;
    int   gseq [4];
    int   nack;
    int   nsw_seen;
    bit   any_ack;

    vecs[0] = '{0, 1'b0, 20,  0, 8'h14, 0, 1'b0, 2};
    vecs[1] = '{1, 1'b0, 22,  0, 8'h16, 0, 1'b0, 2};
    vecs[2] = '{0, 1'b0, 28,  0, 8'h1C, 0, 1'b0, 2};
    vecs[3] = '{1, 1'b1, 22, 28, 0,     3, 1'b0, 4};
    vecs[4] = '{0, 1'b1,  5,  5, 0,     2, 1'b1, 1};
    vecs[5] = '{1, 1'b1,  3,  4, 0,     0, 1'b1, 1};
    vecs[6] = '{0, 1'b1, 10, 11, 0,     1, 1'b0, 2};
    vecs[7] = '{1, 1'b0, 127, 0, 8'hFF, 0, 1'b0, 2};

    reset  = 1'b1;
    req    = 2'b00;
    op     = 2'b00;
    addr_a = 14'd0;
    addr_b = 14'd0;
    wdata  = 16'd0;
    cnt    = 8'd0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack", int'(ack), 0);
    check("rst_err", int'(err), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_grant", int'(grant_id), 0);
    check("rst_strobes", int'({rf_we, rf_swap}), 0);
    check("rst_addrs", int'({rf_address_w, rf_address_A, rf_address_B}), 0);
    check("rst_data", int'(rf_data_w), 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_no_req_busy", int'(busy), 0);
    check("idle_no_req_strobes", int'({rf_we, rf_swap}), 0);

    // single-op vector table
    for (int i = 0; i < 8; i++) run_op(vecs[i]);
    check("rf22_after_swap", int'(rf_m[22]), 8'h1C);
    check("rf28_after_swap", int'(rf_m[28]), 8'h16);

    // both requesters held with WRITEs: strict alternation starting at 0
    @(negedge clk);
    v = '{0, 1'b0, 40, 0, 8'h28, 0, 1'b0, 0};
    drive_fields(v);
    push_exp(v);
    v = '{1, 1'b0, 41, 0, 8'h29, 0, 1'b0, 0};
    drive_fields(v);
    push_exp(v);
    v = '{0, 1'b0, 40, 0, 8'h28, 0, 1'b0, 0};
    push_exp(v);
    v = '{1, 1'b0, 41, 0, 8'h29, 0, 1'b0, 0};
    push_exp(v);
    req  = 2'b11;
    nack = 0;
    for (int c = 0; c < 60 && nack < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack != 2'b00) begin
        gseq[nack] = int'(grant_id);
        nack++;
        if (nack == 4) req = 2'b00;
      end
    end
    check("rr_ack_count", nack, 4);
    if (nack == 4) begin
      check("rr_grant0", gseq[0], 0);
      check("rr_grant1", gseq[1], 1);
      check("rr_grant2", gseq[2], 0);
      check("rr_grant3", gseq[3], 1);
    end
    @(posedge clk);
    @(negedge clk);
    check("rr_idle_after", int'(busy), 0);

    // reset in the middle of a swap burst
    @(negedge clk);
    v = '{0, 1'b1, 50, 51, 0, 5, 1'b0, 0};
    drive_fields(v);
    req[0]   = 1'b1;
    nsw_seen = 0;
    for (int c = 0; c < 20 && nsw_seen < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (rf_swap) nsw_seen++;
    end
    check("abort_swaps_before_reset", nsw_seen, 2);
    req[0] = 1'b0;
    reset  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_swap_low", int'(rf_swap), 0);
    check("abort_busy_low", int'(busy), 0);
    check("abort_no_ack", int'(ack), 0);
    reset   = 1'b0;
    any_ack = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack != 2'b00) any_ack = 1'b1;
    end
    check("abort_no_late_ack", int'(any_ack), 0);
    v = '{1, 1'b0, 60, 0, 8'h3C, 0, 1'b0, 2};
    run_op(v);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
